dsp_frame_sequencer: RTL and testbench

// Host-side sequencer for the DSPCore sample interface. Collects one frame of CHANNELS

---
 rtl/dsp_frame_sequencer.sv | 90 +++++++++
 tb/tb_dsp_frame_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_frame_sequencer.sv
// dsp_frame_sequencer: gathers one channel-serial frame, runs DSPCore once, streams results back out
module dsp_frame_sequencer #(
  parameter int CHANNELS = 8,
  parameter int WIDTH = 36,
  parameter int CORE_CYCLES = 50,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int NW = CORE_CYCLES > 1 ? $clog2(CORE_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] core_inputs [CHANNELS],
  output logic             core_start,
  input  logic [WIDTH-1:0] core_outputs [CHANNELS],
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam logic [1:0] COLLECT = 2'd0, START = 2'd1, RUN = 2'd2, DRAIN = 2'd3;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] in_chan_q, in_chan_d, out_chan_q, out_chan_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] stage_q [CHANNELS], stage_d [CHANNELS];
  logic [WIDTH-1:0] core_in_q [CHANNELS], core_in_d [CHANNELS];
  logic [WIDTH-1:0] outbuf_q [CHANNELS], outbuf_d [CHANNELS];
  logic in_last, out_last;
  assign in_ready = state_q == COLLECT;
  assign busy = state_q != COLLECT;
  assign core_start = state_q == START;
  assign out_valid = state_q == DRAIN;
  assign out_chan = out_chan_q;
  assign out_data = outbuf_q[out_chan_q];
  assign core_inputs = core_in_q;
  assign in_last = in_chan_q == CW'(CHANNELS - 1);
  assign out_last = out_chan_q == CW'(CHANNELS - 1);
  always_comb begin
    state_d = state_q;
    in_chan_d = in_chan_q;
    out_chan_d = out_chan_q;
    cnt_d = cnt_q;
    stage_d = stage_q;
    core_in_d = core_in_q;
    outbuf_d = outbuf_q;
    if (in_ready && in_valid) begin
      stage_d[in_chan_q] = in_data;
      in_chan_d = in_last ? '0 : in_chan_q + 1'b1;
      state_d = in_last ? START : COLLECT;
    end
    // core inputs change only here, so they stay frozen for the whole core run
    if (core_start) begin
      core_in_d = stage_q;
      cnt_d = NW'(CORE_CYCLES - 1);
      state_d = RUN;
    end
    if (state_q == RUN) begin
      cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
      if (cnt_q == '0) begin
        outbuf_d = core_outputs;
        state_d = DRAIN;
      end
    end
    if (out_valid && out_ready) begin
      out_chan_d = out_last ? '0 : out_chan_q + 1'b1;
      state_d = out_last ? COLLECT : DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      in_chan_q <= '0;
      out_chan_q <= '0;
      cnt_q <= '0;
      stage_q <= '{default: '0};
      core_in_q <= '{default: '0};
      outbuf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      in_chan_q <= in_chan_d;
      out_chan_q <= out_chan_d;
      cnt_q <= cnt_d;
      stage_q <= stage_d;
      core_in_q <= core_in_d;
      outbuf_q <= outbuf_d;
    end
  end
endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// tb_dsp_frame_sequencer: directed scenarios against a timed stand-in core (result = input + channel)
module tb_dsp_frame_sequencer;
  localparam int CH = 8, W = 36, C = 50;
  localparam int FRAME = CH + 1 + C + CH;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic in_ready, core_start, out_valid, busy;
  logic [W-1:0] in_data = '0, out_data;
  logic [W-1:0] core_inputs [CH], core_outputs [CH], vin [CH];
  logic [2:0] out_chan;
  int total = 0, bad = 0, cyc = 0, cm = 0;
  int start_cnt = 0, acc_cnt = 0, acc_at_start = -1, dbl = 0;
  logic prev_start = 0, prev_ov = 0;
  logic [W-1:0] got_d [$], exp_q [$];
  logic [2:0] got_c [$];
  int start_q [$], ov_q [$];

  dsp_frame_sequencer #(.CHANNELS(CH), .WIDTH(W), .CORE_CYCLES(C)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_inputs(core_inputs), .core_start(core_start), .core_outputs(core_outputs),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in core: outputs valid only in the single cycle before the expected capture edge
  always @(posedge clk) begin
    if (core_start) cm <= 1;
    else if (cm != 0 && cm <= C) cm <= cm + 1;
    for (int i = 0; i < CH; i++)
      if (cm == C - 1) core_outputs[i] <= core_inputs[i] + W'(i);
      else if (cm == C) core_outputs[i] <= 36'hA_AAAA_AAAA;
  end

  always @(negedge clk) begin
    if (core_start) begin
      start_cnt++;
      start_q.push_back(cyc);
      acc_at_start = acc_cnt;
      if (prev_start) dbl++;
    end
    prev_start = core_start;
    if (in_valid && in_ready) acc_cnt++;
    if (out_valid && !prev_ov) ov_q.push_back(cyc);
    prev_ov = out_valid;
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_c.push_back(out_chan);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start_cnt = 0; acc_cnt = 0; dbl = 0; acc_at_start = -1;
    got_d.delete(); got_c.delete(); start_q.delete(); ov_q.delete(); exp_q.delete();
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < CH; i++) begin
      in_valid = 0;
      repeat (gap - 1) step();
      in_valid = 1;
      in_data = vin[i];
      exp_q.push_back(vin[i] + W'(i));
      for (int n = 0; !in_ready; n++) begin
        if (n == 1000) begin
          total++; bad++;
          $display("FAIL send_timeout in_ready=%0b want=1", in_ready);
          in_valid = 0;
          return;
        end
        step();
      end
      step();
    end
    in_valid = 0;
  endtask

  task automatic wait_idle();
    for (int n = 0; busy; n++) begin
      if (n == 1000) begin
        total++; bad++;
        $display("FAIL idle_timeout busy=%0b want=0", busy);
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; out_ready = 1;
    step(); step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (core_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%0b want=0", core_start); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    total++; if (out_chan !== 3'd0) begin bad++; $display("FAIL rst_out_chan got=%0d want=0", out_chan); end
    for (int i = 0; i < CH; i++) begin
      total++; if (core_inputs[i] !== '0) begin bad++; $display("FAIL rst_core_in[%0d] got=%h want=0", i, core_inputs[i]); end
    end
    reset = 0;
  endtask

  task automatic test_basic();
    clr();
    for (int i = 0; i < CH; i++) vin[i] = W'(i) << 26;
    send_frame(1);
    wait_idle();
    total++; if (start_cnt != 1) begin bad++; $display("FAIL basic_starts got=%0d want=1", start_cnt); end
    total++; if (dbl != 0) begin bad++; $display("FAIL basic_double_start got=%0d want=0", dbl); end
    for (int i = 0; i < CH; i++) begin
      total++; if (core_inputs[i] !== vin[i]) begin bad++; $display("FAIL basic_core_in[%0d] got=%h want=%h", i, core_inputs[i], vin[i]); end
    end
    total++; if (got_d.size() != CH) begin bad++; $display("FAIL basic_out_count got=%0d want=%0d", got_d.size(), CH); end
    for (int i = 0; i < CH && i < got_d.size(); i++) begin
      total++; if (got_d[i] !== exp_q[i]) begin bad++; $display("FAIL basic_out[%0d] got=%h want=%h", i, got_d[i], exp_q[i]); end
      total++; if (got_c[i] !== 3'(i)) begin bad++; $display("FAIL basic_chan[%0d] got=%0d want=%0d", i, got_c[i], i); end
    end
    total++;
    if (start_q.size() < 1 || ov_q.size() < 1 || ov_q[0] - start_q[0] != C + 1) begin
      bad++; $display("FAIL basic_latency got=%0d want=%0d", (start_q.size() && ov_q.size()) ? ov_q[0] - start_q[0] : -1, C + 1);
    end
  endtask

  task automatic test_gapped();
    clr();
    for (int i = 0; i < CH; i++) vin[i] = 36'h8_0000_0000 + W'(i * 1234567);
    send_frame(3);
    wait_idle();
    total++; if (acc_at_start != CH) begin bad++; $display("FAIL gap_accepts_at_start got=%0d want=%0d", acc_at_start, CH); end
    total++; if (start_cnt != 1) begin bad++; $display("FAIL gap_starts got=%0d want=1", start_cnt); end
    for (int i = 0; i < CH; i++) begin
      total++; if (core_inputs[i] !== vin[i]) begin bad++; $display("FAIL gap_core_in[%0d] got=%h want=%h", i, core_inputs[i], vin[i]); end
    end
    total++; if (got_d.size() != CH) begin bad++; $display("FAIL gap_out_count got=%0d want=%0d", got_d.size(), CH); end
    for (int i = 0; i < CH && i < got_d.size(); i++) begin
      total++; if (got_d[i] !== exp_q[i]) begin bad++; $display("FAIL gap_out[%0d] got=%h want=%h", i, got_d[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pd;
    logic [2:0] pc;
    logic stall;
    clr();
    for (int i = 0; i < CH; i++) vin[i] = -(W'(i + 1) << 20);
    send_frame(1);
    stall = 0; pd = '0; pc = '0;
    for (int k = 0; k < 200 && got_d.size() < CH; k++) begin
      if (stall) begin
        total++; if (out_data !== pd || out_chan !== pc) begin bad++; $display("FAIL bp_stable got=%h/%0d want=%h/%0d", out_data, out_chan, pd, pc); end
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
      out_ready = k[0];
      stall = out_valid && !out_ready;
      pd = out_data; pc = out_chan;
      step();
    end
    out_ready = 1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_after got=%0b want=1", in_ready); end
    total++; if (got_d.size() != CH) begin bad++; $display("FAIL bp_out_count got=%0d want=%0d", got_d.size(), CH); end
    for (int i = 0; i < CH && i < got_d.size(); i++) begin
      total++; if (got_d[i] !== exp_q[i] || got_c[i] !== 3'(i)) begin bad++; $display("FAIL bp_out[%0d] got=%h/%0d want=%h/%0d", i, got_d[i], got_c[i], exp_q[i], i); end
    end
  endtask

  task automatic test_hold_valid();
    clr();
    for (int i = 0; i < CH; i++) vin[i] = 36'h0_1234_5678 ^ W'(i << 8);
    send_frame(1);
    in_valid = 1; in_data = '1;
    wait_idle();
    total++; if (acc_cnt != CH) begin bad++; $display("FAIL hold_accepts got=%0d want=%0d", acc_cnt, CH); end
    in_valid = 0;
    total++; if (got_d.size() != CH) begin bad++; $display("FAIL hold_out_count got=%0d want=%0d", got_d.size(), CH); end
    clr();
    for (int i = 0; i < CH; i++) vin[i] = W'(100 + i * 7);
    send_frame(1);
    wait_idle();
    total++; if (start_cnt != 1) begin bad++; $display("FAIL hold_next_starts got=%0d want=1", start_cnt); end
    total++; if (got_d.size() != CH) begin bad++; $display("FAIL hold_next_count got=%0d want=%0d", got_d.size(), CH); end
    for (int i = 0; i < CH && i < got_d.size(); i++) begin
      total++; if (got_d[i] !== exp_q[i] || got_c[i] !== 3'(i)) begin bad++; $display("FAIL hold_next_out[%0d] got=%h/%0d want=%h/%0d", i, got_d[i], got_c[i], exp_q[i], i); end
    end
  endtask

  task automatic test_reset_run();
    clr();
    for (int i = 0; i < CH; i++) vin[i] = W'(i + 1) << 28;
    send_frame(1);
    repeat (10) step();
    total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rr_mid_run busy/out_valid got=%0b/%0b want=1/0", busy, out_valid); end
    reset = 1;
    step();
    reset = 0;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rr_collect in_ready/busy got=%0b/%0b want=1/0", in_ready, busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_out_valid got=%0b want=0", out_valid); end
    for (int i = 0; i < CH; i++) begin
      total++; if (core_inputs[i] !== '0) begin bad++; $display("FAIL rr_core_in[%0d] got=%h want=0", i, core_inputs[i]); end
    end
    clr();
    repeat (C + 20) step();
    total++; if (ov_q.size() != 0 || got_d.size() != 0 || start_cnt != 0) begin bad++; $display("FAIL rr_quiet ov=%0d out=%0d starts=%0d want=0/0/0", ov_q.size(), got_d.size(), start_cnt); end
    clr();
    for (int i = 0; i < CH; i++) vin[i] = W'(i) << 26;
    send_frame(1);
    wait_idle();
    total++; if (start_cnt != 1) begin bad++; $display("FAIL rr_next_starts got=%0d want=1", start_cnt); end
    total++; if (got_d.size() != CH) begin bad++; $display("FAIL rr_next_count got=%0d want=%0d", got_d.size(), CH); end
    for (int i = 0; i < CH && i < got_d.size(); i++) begin
      total++; if (got_d[i] !== exp_q[i] || got_c[i] !== 3'(i)) begin bad++; $display("FAIL rr_next_out[%0d] got=%h/%0d want=%h/%0d", i, got_d[i], got_c[i], exp_q[i], i); end
    end
    total++;
    if (start_q.size() < 1 || ov_q.size() < 1 || ov_q[0] - start_q[0] != C + 1) begin
      bad++; $display("FAIL rr_latency got=%0d want=%0d", (start_q.size() && ov_q.size()) ? ov_q[0] - start_q[0] : -1, C + 1);
    end
  endtask

  task automatic test_back_to_back();
    clr();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < CH; i++)
        vin[i] = W'(longint'($sin(2.0 * 3.14159265358979 * real'(f * CH + i) * 4800.0 / 48000.0) * 536870912.0));
      send_frame(1);
    end
    wait_idle();
    total++; if (start_cnt != 3) begin bad++; $display("FAIL b2b_starts got=%0d want=3", start_cnt); end
    total++; if (dbl != 0) begin bad++; $display("FAIL b2b_double_start got=%0d want=0", dbl); end
    for (int f = 1; f < 3 && f < start_q.size(); f++) begin
      total++; if (start_q[f] - start_q[f-1] != FRAME) begin bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", f, start_q[f] - start_q[f-1], FRAME); end
    end
    total++; if (got_d.size() != 3 * CH) begin bad++; $display("FAIL b2b_out_count got=%0d want=%0d", got_d.size(), 3 * CH); end
    for (int i = 0; i < 3 * CH && i < got_d.size(); i++) begin
      total++; if (got_d[i] !== exp_q[i] || got_c[i] !== 3'(i % CH)) begin bad++; $display("FAIL b2b_out[%0d] got=%h/%0d want=%h/%0d", i, got_d[i], got_c[i], exp_q[i], i % CH); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_backpressure();
    test_hold_valid();
    test_reset_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
